// File: rtl/poci_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : poci_readout_ctrl
// Description : Serial register readout controller. Shifts in an 8-bit
//               register address LSB first on pico, then streams the
//               selected register byte(s) out on poci LSB first, with
//               optional burst address auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
module poci_readout_ctrl #(
  parameter int NUM_REGS = 59,
  parameter int AUTO_INC = 1
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       cs_n,
  input  logic       pico,
  input  logic [7:0] mux_data,
  output logic [7:0] mux_sel,
  output logic       poci,
  output logic       busy,
  output logic       byte_done,
  output logic       addr_err
);

  localparam logic [7:0] c_max_addr = 8'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t     r_state,     w_state_nxt;
  logic [2:0] r_bit_cnt,   w_bit_cnt_nxt;
  logic [7:0] r_addr,      w_addr_nxt;
  logic       r_poci,      w_poci_nxt;
  logic       r_byte_done, w_byte_done_nxt;
  logic       r_addr_err,  w_addr_err_nxt;

  // Address as it will be once the final (MSB) address bit is captured.
  logic [7:0] w_addr_full;
  // Current address maps onto a real mux entry (0 is the reserved slot).
  logic       w_addr_in_range;
  // Current address holds real data; reserved 0 and invalid read as zero.
  logic       w_addr_readable;

  assign w_addr_full     = {pico, r_addr[6:0]};
  assign w_addr_in_range = (r_addr <= c_max_addr);
  assign w_addr_readable = w_addr_in_range && (r_addr != 8'd0);

  // State and datapath registers; reset forces the idle, all-zero condition.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_addr      <= 8'd0;
      r_poci      <= 1'b0;
      r_byte_done <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_poci      <= w_poci_nxt;
      r_byte_done <= w_byte_done_nxt;
      r_addr_err  <= w_addr_err_nxt;
    end
  end

  // Next-state and datapath update; a high cs_n aborts from any state.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_addr_nxt      = r_addr;
    w_poci_nxt      = r_poci;
    w_byte_done_nxt = 1'b0;
    w_addr_err_nxt  = r_addr_err;

    if (cs_n) begin
      w_state_nxt    = IDLE;
      w_bit_cnt_nxt  = 3'd0;
      w_addr_nxt     = 8'd0;
      w_poci_nxt     = 1'b0;
      w_addr_err_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_addr_nxt     = {7'd0, pico};
          w_bit_cnt_nxt  = 3'd1;
          w_poci_nxt     = 1'b0;
          w_addr_err_nxt = 1'b0;
          w_state_nxt    = ADDR;
        end
        ADDR: begin
          w_addr_nxt[r_bit_cnt] = pico;
          if (r_bit_cnt == 3'd7) begin
            w_bit_cnt_nxt  = 3'd0;
            w_state_nxt    = SEND;
            // Error is judged once, on the full address, and then held.
            w_addr_err_nxt = (w_addr_full > c_max_addr);
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
        SEND: begin
          w_poci_nxt    = w_addr_readable ? mux_data[r_bit_cnt] : 1'b0;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_byte_done_nxt = 1'b1;
            if (AUTO_INC != 0) begin
              // Wrap past the top (or out of range) back to the first real register.
              w_addr_nxt = (r_addr >= c_max_addr) ? 8'd1 : (r_addr + 8'd1);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Mux select only ever carries a valid address, and only while sending.
  always_comb begin
    mux_sel = 8'd0;
    if ((r_state == SEND) && w_addr_in_range) begin
      mux_sel = r_addr;
    end
  end

  assign busy      = (r_state != IDLE);
  assign poci      = r_poci;
  assign byte_done = r_byte_done;
  assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_poci_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_poci_readout_ctrl
// Description : Self-checking bench for poci_readout_ctrl. Two instances
//               (auto-increment on and off) share stimulus; expected bytes
//               come from a register-file model and address-walk rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poci_readout_ctrl;

  localparam int NREG = 59;

  logic       sclk = 1'b0;
  logic       rstn;
  logic       cs_n;
  logic       pico;
  logic [7:0] mux_data_a, mux_sel_a, mux_data_n, mux_sel_n;
  logic       poci_a, busy_a, bd_a, err_a;
  logic       poci_n, busy_n, bd_n, err_n;

  logic [7:0] regs [0:255];
  int checks   = 0;
  int failures = 0;

  // Register mux model: unmapped entries return a visible garbage pattern.
  assign mux_data_a = regs[mux_sel_a];
  assign mux_data_n = regs[mux_sel_n];

  poci_readout_ctrl #(.NUM_REGS(NREG), .AUTO_INC(1)) dut_inc (
    .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .pico(pico),
    .mux_data(mux_data_a), .mux_sel(mux_sel_a), .poci(poci_a),
    .busy(busy_a), .byte_done(bd_a), .addr_err(err_a)
  );

  poci_readout_ctrl #(.NUM_REGS(NREG), .AUTO_INC(0)) dut_fix (
    .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .pico(pico),
    .mux_data(mux_data_n), .mux_sel(mux_sel_n), .poci(poci_n),
    .busy(busy_n), .byte_done(bd_n), .addr_err(err_n)
  );

  always #5 sclk = ~sclk;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_sel(input logic [7:0] a);
    return (a <= 8'(NREG)) ? a : 8'd0;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] a);
    return ((a == 8'd0) || (a > 8'(NREG))) ? 8'd0 : regs[a];
  endfunction

  // The mux must never be asked for an unmapped entry.
  always @(negedge sclk) begin
    check_val("sel_range_inc", int'(mux_sel_a <= 8'(NREG)), 1);
    check_val("sel_range_fix", int'(mux_sel_n <= 8'(NREG)), 1);
  end

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"},  int'(busy_a), 0);
    check_val({tag, "_busyn"}, int'(busy_n), 0);
    check_val({tag, "_poci"},  int'(poci_a), 0);
    check_val({tag, "_pocin"}, int'(poci_n), 0);
    check_val({tag, "_bd"},    int'(bd_a), 0);
    check_val({tag, "_bdn"},   int'(bd_n), 0);
    check_val({tag, "_err"},   int'(err_a), 0);
    check_val({tag, "_errn"},  int'(err_n), 0);
    check_val({tag, "_sel"},   int'(mux_sel_a), 0);
    check_val({tag, "_seln"},  int'(mux_sel_n), 0);
  endtask

  // One frame: 8 address bits, then nbits data edges, then one cs_n-high edge.
  // Called at a negedge; returns at a negedge.
  task automatic run_frame(input logic [7:0] addr, input int nbits);
    logic [7:0] a_inc, a_fix, e_inc, e_fix;
    logic       err;
    int         k;
    a_inc = addr;
    a_fix = addr;
    err   = (addr > 8'(NREG));
    e_inc = 8'd0;
    e_fix = 8'd0;
    for (int i = 0; i < 8; i++) begin
      cs_n = 1'b0;
      pico = addr[i];
      @(posedge sclk); #1;
      check_val("addr_busy",  int'(busy_a), 1);
      check_val("addr_busyn", int'(busy_n), 1);
      check_val("addr_poci",  int'(poci_a), 0);
      check_val("addr_bd",    int'(bd_a), 0);
      check_val("addr_err",   int'(err_a), (i == 7) ? int'(err) : 0);
      check_val("addr_errn",  int'(err_n), (i == 7) ? int'(err) : 0);
      check_val("addr_sel",   int'(mux_sel_a), (i == 7) ? int'(exp_sel(addr)) : 0);
      check_val("addr_seln",  int'(mux_sel_n), (i == 7) ? int'(exp_sel(addr)) : 0);
      @(negedge sclk);
    end
    for (int b = 0; b < nbits; b++) begin
      k = b % 8;
      if (k == 0) begin
        e_inc = exp_byte(a_inc);
        e_fix = exp_byte(a_fix);
        check_val("byte_sel",  int'(mux_sel_a), int'(exp_sel(a_inc)));
        check_val("byte_seln", int'(mux_sel_n), int'(exp_sel(a_fix)));
      end
      pico = 1'($urandom);
      @(posedge sclk); #1;
      check_val("data_poci",  int'(poci_a), int'(e_inc[k]));
      check_val("data_pocin", int'(poci_n), int'(e_fix[k]));
      check_val("data_bd",    int'(bd_a), (k == 7) ? 1 : 0);
      check_val("data_bdn",   int'(bd_n), (k == 7) ? 1 : 0);
      check_val("data_err",   int'(err_a), int'(err));
      check_val("data_errn",  int'(err_n), int'(err));
      check_val("data_busy",  int'(busy_a), 1);
      if (k == 7) begin
        a_inc = (a_inc >= 8'(NREG)) ? 8'd1 : 8'(a_inc + 8'd1);
      end
      @(negedge sclk);
    end
    cs_n = 1'b1;
    pico = 1'b0;
    @(posedge sclk); #1;
    check_idle("end");
    @(negedge sclk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra;
    int         nb;
    rstn = 1'b0;
    cs_n = 1'b1;
    pico = 1'b0;
    for (int i = 0; i < 256; i++) regs[i] = 8'hEE;
    regs[0] = 8'h00;
    for (int i = 1; i <= NREG; i++) regs[i] = 8'($urandom);
    regs[5]  = 8'hA5;
    regs[58] = 8'h11;
    regs[59] = 8'h22;
    regs[1]  = 8'h33;
    #3;
    check_idle("reset");
    @(negedge sclk);
    rstn = 1'b1;
    @(posedge sclk); #1;
    check_idle("post_reset");
    @(negedge sclk);

    run_frame(8'd5, 8);        // single read
    run_frame(8'd58, 24);      // burst across the top wrap
    run_frame(8'd0, 16);       // reserved address
    run_frame(8'd200, 16);     // invalid address
    run_frame(8'd9, 4);        // abort mid-byte
    run_frame(8'd7, 8);
    run_frame(8'd3, 16);       // fixed-address instance repeats reg3
    run_frame(8'd59, 9);

    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = 8'($urandom_range(0, 255));
        1:       ra = 8'($urandom_range(NREG - 2, NREG + 2));
        default: ra = 8'($urandom_range(0, NREG));
      endcase
      nb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 23) : 8 * $urandom_range(1, 4);
      run_frame(ra, nb);
    end

    // Asynchronous reset in the middle of a data byte.
    ra = 8'd12;
    for (int i = 0; i < 11; i++) begin
      cs_n = 1'b0;
      pico = (i < 8) ? ra[i] : 1'($urandom);
      @(posedge sclk);
      if (i < 10) @(negedge sclk);
    end
    #2;
    rstn = 1'b0;
    #1;
    check_idle("async_rst");
    @(posedge sclk); #1;
    check_idle("rst_held");
    @(negedge sclk);
    rstn = 1'b1;               // released with cs_n low: next edge starts a frame
    run_frame(8'd20, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
